// File: rtl/position_sample_fifo.sv
// First-word-fall-through FIFO of demodulated QPD position records {seq, x1, x2}.
// Every tick consumes a sequence number, so gaps in seq_o expose dropped samples.
module position_sample_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 24
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tick_i,
  input  logic signed [DATA_W-1:0]   x1_i,
  input  logic signed [DATA_W-1:0]   x2_i,
  input  logic                       clear_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [31:0]                seq_o,
  output logic signed [DATA_W-1:0]   x1_o,
  output logic signed [DATA_W-1:0]   x2_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [15:0]                overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0]               seq;
    logic signed [DATA_W-1:0]  x1;
    logic signed [DATA_W-1:0]  x2;
  } rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rec_t        mem_q [DEPTH];
  rec_t        head_q, head_d, in_rec;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, rd_next, level;
  logic [31:0] seq_q, seq_d;
  logic [15:0] ovf_q, ovf_d;
  logic        empty, full, pop, push, drop;

  assign in_rec  = '{seq: seq_q, x1: x1_i, x2: x2_i};
  assign level   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop     = !empty && ready_i;
  assign push    = tick_i && (!full || pop);
  assign drop    = tick_i && full && !pop;
  assign rd_next = rd_q + PTR_ONE;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q;
    head_d = head_q;
    seq_d  = seq_q + {31'd0, tick_i};
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_ONE;
      if (pop)  rd_d = rd_next;
      if (drop) ovf_d = sat_inc16(ovf_q);
      // Head register is preloaded so the read path adds no latency: it takes the
      // next stored record, or the incoming sample when that becomes the head.
      if (pop && level != PTR_ONE)
        head_d = mem_q[rd_next[AW-1:0]];
      else if (push && (empty || pop))
        head_d = in_rec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      seq_q  <= '0;
      ovf_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem_q[wr_q[AW-1:0]] <= in_rec;
  end

  assign valid_o    = !empty;
  assign level_o    = level;
  assign overflow_o = ovf_q;
  assign seq_o      = head_q.seq;
  assign x1_o       = head_q.x1;
  assign x2_o       = head_q.x2;

endmodule

// File: tb/tb_position_sample_fifo.sv
// Directed and randomized bench for position_sample_fifo against a queue-based model.
module tb_position_sample_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 24;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0, tick = 1'b0, ready = 1'b0, clear = 1'b0;
  logic signed [DW-1:0] x1 = '0, x2 = '0;
  logic                 valid_o;
  logic [31:0]          seq_o;
  logic signed [DW-1:0] x1_o, x2_o;
  logic [$clog2(DEPTH):0] level_o;
  logic [15:0]          overflow_o;

  position_sample_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_i(rst), .tick_i(tick), .x1_i(x1), .x2_i(x2),
    .clear_i(clear), .valid_o(valid_o), .ready_i(ready), .seq_o(seq_o),
    .x1_o(x1_o), .x2_o(x2_o), .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned          seq;
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] x2;
  } rec_t;

  rec_t        mq[$];
  rec_t        eh;
  int unsigned m_seq;
  int unsigned m_ovf;
  int          passed = 0, total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic compare();
    check("valid", 64'(valid_o), 64'(mq.size() != 0));
    check("level", 64'(level_o), 64'(mq.size()));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
    check("seq", 64'(seq_o), 64'(eh.seq));
    check("x1", 64'(x1_o), 64'(eh.x1));
    check("x2", 64'(x2_o), 64'(eh.x2));
  endtask

  task automatic step(input logic t, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                      input logic r, input logic c, input bit do_cmp);
    bit popped, was_full;
    @(negedge clk);
    rst = 1'b0; tick = t; x1 = a; x2 = b; ready = r; clear = c;
    if (c) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      popped   = (mq.size() > 0) && r;
      was_full = (mq.size() == DEPTH);
      if (popped) void'(mq.pop_front());
      if (t) begin
        if (!was_full || popped) mq.push_back('{seq: m_seq, x1: a, x2: b});
        else if (m_ovf < 65535) m_ovf++;
      end
    end
    if (t) m_seq++;
    if (mq.size() > 0) eh = mq[0];
    @(posedge clk); #1;
    if (do_cmp) compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'($urandom); ready = 1'b1; clear = 1'b0;
    x1 = DW'($urandom); x2 = DW'($urandom);
    mq.delete(); m_seq = 0; m_ovf = 0;
    eh = '{seq: 0, x1: '0, x2: '0};
    @(posedge clk); #1;
    compare();
  endtask

  task automatic rnd_tick(input logic r);
    step(1'b1, DW'($urandom), DW'($urandom), r, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();

    // Three ticks, then drain in order
    step(1'b1, 100, -1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 200, -2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 300, -3, 1'b0, 1'b0, 1'b1);
    check("t1_level", 64'(level_o), 64'd3);
    check("t1_seq", 64'(seq_o), 64'd0);
    check("t1_x1", 64'(x1_o), 64'd100);
    check("t1_x2", 64'(x2_o), 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      check("t1_drain_seq", 64'(seq_o), 64'(i));
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    end
    check("t1_empty_valid", 64'(valid_o), 64'd0);
    check("t1_empty_level", 64'(level_o), 64'd0);

    // Overfill by four, drain, next tick carries seq 20
    do_reset();
    for (int i = 0; i < 20; i++) rnd_tick(1'b0);
    check("t2_level", 64'(level_o), 64'd16);
    check("t2_ovf", 64'(overflow_o), 64'd4);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain_seq", 64'(seq_o), 64'(i));
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    end
    rnd_tick(1'b0);
    check("t2_next_seq", 64'(seq_o), 64'd20);

    // Full plus simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) rnd_tick(1'b0);
    rnd_tick(1'b1);
    check("t3_level", 64'(level_o), 64'd16);
    check("t3_ovf", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Empty with tick and ready together
    do_reset();
    rnd_tick(1'b1);
    check("t4_valid", 64'(valid_o), 64'd1);
    check("t4_level", 64'(level_o), 64'd1);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), DW'($urandom), DW'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3), 1'b1);

    // Reset with five records buffered
    do_reset();
    for (int i = 0; i < 5; i++) rnd_tick(1'b0);
    do_reset();
    check("t5_valid", 64'(valid_o), 64'd0);
    check("t5_level", 64'(level_o), 64'd0);
    check("t5_seq", 64'(seq_o), 64'd0);
    check("t5_x1", 64'(x1_o), 64'd0);
    rnd_tick(1'b0);
    check("t5_first_seq", 64'(seq_o), 64'd0);

    // Overflow saturation and clear
    do_reset();
    for (int i = 0; i < 16; i++) rnd_tick(1'b0);
    for (int i = 0; i < 65534; i++) step(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    compare();
    check("t6_ovf_pre", 64'(overflow_o), 64'hFFFE);
    for (int i = 0; i < 3; i++) rnd_tick(1'b0);
    check("t6_ovf_sat", 64'(overflow_o), 64'hFFFF);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("t6_clr_ovf", 64'(overflow_o), 64'd0);
    check("t6_clr_level", 64'(level_o), 64'd0);
    rnd_tick(1'b0);
    check("t6_seq_cont", 64'(seq_o), 64'(16 + 65534 + 3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/position_sample_fifo.md
# position_sample_fifo

Buffers demodulated QPD position samples between the demodulator and the processor-side register readout. Each demodulator done pulse pushes one record (sequence number, x1, x2) into a first-word-fall-through FIFO. The consumer drains records through a valid/ready handshake, so no sample is silently skipped or read twice. Overflow and occupancy are reported for diagnostics.

## Interface
Parameters:
- DEPTH, 16, number of records stored; power of two, 4..1024
- DATA_W, 24, width of each signed position word

Ports (clock and reset first):
- clk_i  in  1  system clock; one clock domain, all logic on the rising edge
- reset_i  in  1  reset, synchronous and active-high
- tick_i  in  1  one-cycle pulse: a new demodulator sample is present on x1_i/x2_i
- x1_i  in  DATA_W  signed x1 position from the demodulator
- x2_i  in  DATA_W  signed x2 position from the demodulator
- clear_i  in  1  synchronous flush: empties the FIFO and zeroes overflow_o; seq counter untouched
- valid_o  out  1  head record is present on seq_o/x1_o/x2_o
- ready_i  in  1  consumer accepts the head record this cycle
- seq_o  out  32  sequence number of the head record
- x1_o  out  DATA_W  x1 of the head record
- x2_o  out  DATA_W  x2 of the head record
- level_o  out  $clog2(DEPTH)+1  current record count, 0..DEPTH
- overflow_o  out  16  number of dropped samples, saturating

## Operation
- Internal 32-bit seq counter:
  - increments on every tick_i, including dropped samples
  - the record takes the value before the increment
  - wraps 0xFFFFFFFF -> 0
  - a gap in seq_o therefore exposes drops.
- Push: tick_i=1 and (not full, or pop in the same cycle) -> write {seq, x1_i, x2_i} at the write pointer.
- Pop: valid_o=1 and ready_i=1 -> advance the read pointer.
  - ready_i is ignored when empty.
- Full and tick_i with no pop: sample dropped, FIFO unchanged, overflow_o += 1, saturating at 0xFFFF. seq still increments.
- Simultaneous push+pop:
  - level unchanged.
  - When full, the push is accepted and is not an overflow.
  - When empty, only the push takes effect, since valid_o=0.
- Pointers: log2(DEPTH)+1 bits with a wrap bit. Full = same index and opposite wrap bit. Empty = pointers equal.
- Outputs are first-word-fall-through. seq_o/x1_o/x2_o always show the head record and are stable while valid_o=1 and ready_i=0.
- When valid_o=0, data outputs hold their last value. Consumers must not interpret them.
- clear_i:
  - has priority over push and pop in the same cycle; both are discarded.
  - empties the FIFO and zeroes overflow_o.
  - still increments seq if tick_i=1 that cycle.
- reset_i has priority over everything.

## Timing
- Reset values:
  - valid_o=0, level_o=0, overflow_o=0
  - seq_o=0, x1_o=0, x2_o=0
  - internal seq=0, both pointers 0.
- Write latency: a sample pushed at edge N gives valid_o=1 after edge N, with level_o already updated.
- Pop: the record accepted at edge N is replaced by the next record, or valid_o falls, after edge N.
- level_o and overflow_o are registered and updated on the same edge as the push, pop or drop.
- Reset mid-operation: all stored records are discarded. The first record after reset carries seq=0.
- Throughput: one push and one pop per cycle sustained. Back-to-back tick_i on consecutive cycles is supported.
- Storage: inferred RAM or registers. The read path must not add a cycle of latency beyond the above.

## Test plan
- After reset, 3 ticks with x1=100,200,300 and x2=-1,-2,-3, ready_i=0:
  - level_o=3, valid_o=1, head seq_o=0, x1_o=100, x2_o=-1.
  - Then ready_i=1 for 3 cycles yields seq 0,1,2 in order, after which valid_o=0 and level_o=0.
- DEPTH=16, ready_i=0, 20 ticks:
  - level_o=16, overflow_o=4.
  - Draining yields seq 0..15.
  - The next tick stores seq=20.
- Full FIFO with tick_i and ready_i high in the same cycle:
  - level_o stays 16, overflow_o unchanged.
  - The new record is appended at the tail.
- Empty FIFO with tick_i=1 and ready_i=1: valid_o=1 and level_o=1 next cycle, with the record not consumed.
- Overflow saturation:
  - Preload overflow to 0xFFFE via 65534 drops.
  - 3 further drops give overflow_o=0xFFFF.
  - clear_i then gives overflow_o=0 and level_o=0, and the seq count continues.
- Assert reset_i for 1 cycle while 5 records are buffered:
  - valid_o=0, level_o=0, outputs 0.
  - The next tick produces seq_o=0.
